// File: rtl/blend_sequencer.sv
// Colour-effect sequencer: alpha blend, brighten or darken one BGR555 pixel, one channel per cycle.
// Optional macro BLEND_FASTPATH_EN: passthrough pixels bypass the channel states (latency 1).
module blend_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] top_color,
  input  logic [14:0] bot_color,
  input  logic        top_is_t1,
  input  logic        bot_is_t2,
  input  logic [15:0] bldcnt,
  input  logic [15:0] bldalpha,
  input  logic [15:0] bldy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_color,
  output logic        busy
);

  localparam int DATA_W = 15;
  localparam int COEF_W = 5;
  localparam logic signed [11:0] CH_MAX = 12'sd31;

  typedef enum logic [2:0] {IDLE, CH_R, CH_G, CH_B, OUT} state_t;
  typedef enum logic [1:0] {OP_PASS, OP_ALPHA, OP_BRIGHT, OP_DARK} op_t;

  state_t state, state_nxt;
  op_t    op_in, op_p0;
  logic   accept;
  logic   fast_in;

  logic [DATA_W-1:0] top_p0, bot_p0, res_p1;
  logic [COEF_W-1:0] eva_p0, evb_p0, evy_p0;
  logic [4:0]        i1, i2, ch_res;
  logic signed [11:0] i1_s, i2_s, eva_s, evb_s, evy_s, ch_sum;

  logic unused_bits;
  assign unused_bits = ^{bldcnt[15:8], bldcnt[5:0], bldalpha[15:13], bldalpha[7:5], bldy[15:5]};

  function automatic logic [COEF_W-1:0] clamp_ev(input logic [COEF_W-1:0] ev);
    return (ev > 5'd16) ? 5'd16 : ev;
  endfunction

  function automatic logic [4:0] sat_ch(input logic signed [11:0] v);
    if (v < 12'sd0)
      return 5'd0;
    else if (v > CH_MAX)
      return 5'd31;
    else
      return v[4:0];
  endfunction

  always_comb begin
    op_in = OP_PASS;
    case (bldcnt[7:6])
      2'b01: if (top_is_t1 && bot_is_t2) op_in = OP_ALPHA;
      2'b10: if (top_is_t1) op_in = OP_BRIGHT;
      2'b11: if (top_is_t1) op_in = OP_DARK;
      default: op_in = OP_PASS;
    endcase
  end

`ifdef BLEND_FASTPATH_EN
  assign fast_in = (op_in == OP_PASS);
`else
  assign fast_in = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = fast_in ? OUT : CH_R;
      end
      CH_R: state_nxt = CH_G;
      CH_G: state_nxt = CH_B;
      CH_B: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shared channel unit: the state picks which 5-bit field is being processed
  always_comb begin
    i1 = top_p0[4:0];
    i2 = bot_p0[4:0];
    case (state)
      CH_G: begin i1 = top_p0[9:5];   i2 = bot_p0[9:5];   end
      CH_B: begin i1 = top_p0[14:10]; i2 = bot_p0[14:10]; end
      default: ;
    endcase
  end

  assign i1_s  = $signed({7'b0, i1});
  assign i2_s  = $signed({7'b0, i2});
  assign eva_s = $signed({7'b0, eva_p0});
  assign evb_s = $signed({7'b0, evb_p0});
  assign evy_s = $signed({7'b0, evy_p0});

  always_comb begin
    ch_sum = i1_s;
    case (op_p0)
      OP_ALPHA:  ch_sum = (i1_s * eva_s + i2_s * evb_s) >>> 4;
      OP_BRIGHT: ch_sum = i1_s + (((CH_MAX - i1_s) * evy_s) >>> 4);
      OP_DARK:   ch_sum = i1_s - ((i1_s * evy_s) >>> 4);
      default:   ch_sum = i1_s;
    endcase
    ch_res = sat_ch(ch_sum);
  end

  // Stage p0: snapshot on accept; stage p1: per-channel result fields
  always_ff @(posedge clock) begin
    if (reset) begin
      top_p0 <= '0;
      bot_p0 <= '0;
      op_p0  <= OP_PASS;
      eva_p0 <= '0;
      evb_p0 <= '0;
      evy_p0 <= '0;
      res_p1 <= '0;
    end else if (accept) begin
      top_p0 <= top_color;
      bot_p0 <= bot_color;
      op_p0  <= op_in;
      eva_p0 <= clamp_ev(bldalpha[4:0]);
      evb_p0 <= clamp_ev(bldalpha[12:8]);
      evy_p0 <= clamp_ev(bldy[4:0]);
      if (fast_in) res_p1 <= top_color;
    end else begin
      case (state)
        CH_R: res_p1[4:0]   <= ch_res;
        CH_G: res_p1[9:5]   <= ch_res;
        CH_B: res_p1[14:10] <= ch_res;
        default: ;
      endcase
    end
  end

  assign out_color = res_p1;

endmodule

// File: tb/tb_blend_sequencer.sv
// Scoreboard bench for blend_sequencer: random and directed pixels against a per-channel arithmetic model.
module tb_blend_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] top_color, bot_color;
  logic        top_is_t1, bot_is_t2;
  logic [15:0] bldcnt, bldalpha, bldy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] out_color;
  logic        busy;

  blend_sequencer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .top_color(top_color), .bot_color(bot_color), .top_is_t1(top_is_t1), .bot_is_t2(bot_is_t2),
    .bldcnt(bldcnt), .bldalpha(bldalpha), .bldy(bldy), .out_valid(out_valid),
    .out_ready(out_ready), .out_color(out_color), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [14:0] color;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall_left = 0;
  bit          hold = 0;
  logic [14:0] held_color;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic int ev_of(logic [4:0] v);
    return (v > 5'd16) ? 16 : int'(v);
  endfunction

  function automatic bit is_pass(logic t1, logic t2, logic [15:0] cnt);
    int mode = int'(cnt[7:6]);
    return !((mode == 1 && t1 && t2) || (mode >= 2 && t1));
  endfunction

  function automatic logic [14:0] model(logic [14:0] top, logic [14:0] bot, logic t1, logic t2,
                                        logic [15:0] cnt, logic [15:0] alpha, logic [15:0] y);
    int mode = int'(cnt[7:6]);
    int eva = ev_of(alpha[4:0]);
    int evb = ev_of(alpha[12:8]);
    int evy = ev_of(y[4:0]);
    logic [14:0] res = '0;
    for (int c = 0; c < 3; c++) begin
      int a = int'(top[5*c +: 5]);
      int b = int'(bot[5*c +: 5]);
      int r;
      if (mode == 1 && t1 && t2) begin
        r = (a * eva + b * evb) / 16;
        if (r > 31) r = 31;
      end else if (mode == 2 && t1)
        r = a + ((31 - a) * evy) / 16;
      else if (mode == 3 && t1)
        r = a - (a * evy) / 16;
      else
        r = a;
      res[5*c +: 5] = r[4:0];
    end
    return res;
  endfunction

  function automatic int lat_of(logic t1, logic t2, logic [15:0] cnt);
`ifdef BLEND_FASTPATH_EN
    return is_pass(t1, t2, cnt) ? 1 : 4;
`else
    return is_pass(t1, t2, cnt) ? 4 : 4;
`endif
  endfunction

  task automatic send(input logic [14:0] top, input logic [14:0] bot, input logic t1, input logic t2,
                      input logic [15:0] cnt, input logic [15:0] alpha, input logic [15:0] y,
                      input int forced);
    exp_t e;
    int   waited = 0;
    @(negedge clock);
    in_valid = 1'b1; top_color = top; bot_color = bot; top_is_t1 = t1; bot_is_t2 = t2;
    bldcnt = cnt; bldalpha = alpha; bldy = y;
    while (!in_ready && waited < 60) begin
      @(negedge clock);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.color = (forced < 0) ? model(top, bot, t1, t2, cnt, alpha, y) : forced[14:0];
    e.acc   = cyc;
    e.lat   = lat_of(t1, t2, cnt);
    sbq.push_back(e);
    @(negedge clock);
    // Scramble everything after accept; the pixel in flight must not notice
    in_valid = 1'b0;
    top_color = 15'($urandom); bot_color = 15'($urandom);
    top_is_t1 = 1'($urandom); bot_is_t2 = 1'($urandom);
    bldcnt = 16'($urandom); bldalpha = 16'($urandom); bldy = 16'($urandom);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sbq.size() != 0 || busy) && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (sbq.size() != 0 || busy) check("drain_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      hold = 0;
      out_ready = 1'b0;
    end else begin
      check("busy_vs_ready", {31'd0, busy}, {31'd0, !in_ready});
      if (out_valid) begin
        check("in_ready_in_out", {31'd0, in_ready}, 32'd0);
        if (!hold) begin
          if (sbq.size() == 0) begin
            check("unexpected_output", {17'd0, out_color}, 32'hFFFF_FFFF);
          end else begin
            mon_e = sbq.pop_front();
            check("color", {17'd0, out_color}, {17'd0, mon_e.color});
            check("latency", cyc, mon_e.acc + mon_e.lat);
            held_color = out_color;
          end
        end else begin
          check("hold_stable", {17'd0, out_color}, {17'd0, held_color});
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(3) != 0);
        end
        hold = !out_ready;
      end else begin
        out_ready = 1'($urandom_range(1));
        hold = 0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    top_color = '0; bot_color = '0; top_is_t1 = 1'b0; bot_is_t2 = 1'b0;
    bldcnt = '0; bldalpha = '0; bldy = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_color", {17'd0, out_color}, 32'd0);

    send(15'h7FFF, 15'h0000, 1'b1, 1'b1, 16'h0040, 16'h0808, 16'h0000, 32'h3DEF);
    send(15'h5294, 15'h5294, 1'b1, 1'b1, 16'h0040, 16'h1010, 16'h0000, 32'h7FFF);
    send(15'h5294, 15'h5294, 1'b1, 1'b1, 16'h0040, 16'h1014, 16'h0000, 32'h7FFF);
    send(15'h0000, 15'h1111, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h0010, 32'h7FFF);
    send(15'h7FFF, 15'h0000, 1'b1, 1'b0, 16'h00C0, 16'h0000, 16'h0008, 32'h4210);
    send(15'h1234, 15'h5555, 1'b1, 1'b0, 16'h0040, 16'h0808, 16'h0000, 32'h1234);
    wait_idle();

    stall_left = 5;
    send(15'($urandom), 15'($urandom), 1'b1, 1'b1, 16'h0040, 16'h0A06, 16'h0000, -1);
    wait_idle();

    send(15'h4321, 15'h0F0F, 1'b1, 1'b1, 16'h0040, 16'h0404, 16'h0000, -1);
    @(negedge clock);
    reset = 1'b1;
    sbq.delete(sbq.size() - 1);
    @(negedge clock);
    reset = 1'b0;
    check("rst_chg_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_chg_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_chg_busy", {31'd0, busy}, 32'd0);
    check("rst_chg_out_color", {17'd0, out_color}, 32'd0);
    repeat (6) @(negedge clock);

    for (int k = 0; k < 150; k++) begin
      logic [15:0] cnt;
      cnt = 16'($urandom);
      send(15'($urandom), 15'($urandom), 1'($urandom), 1'($urandom), cnt,
           16'($urandom), 16'($urandom), -1);
      repeat ($urandom_range(2)) @(negedge clock);
    end
    wait_idle();
    check("queue_empty", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blend_sequencer.md
BLEND_SEQUENCER -- requirements
Module: blend_sequencer

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Port list (name  direction  width  meaning):
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  a pixel pair is offered.
- in_ready  out  1  the block accepts a pixel this cycle.
- top_color  in  15  top-layer pixel, BGR555 (R=[4:0], G=[9:5], B=[14:10]).
- bot_color  in  15  second-layer pixel, BGR555.
- top_is_t1  in  1  top layer is a 1st target.
- bot_is_t2  in  1  bottom layer is a 2nd target.
- bldcnt  in  16  effect register; mode=[7:6].
- bldalpha  in  16  EVA=[4:0], EVB=[12:8].
- bldy  in  16  EVY=[4:0].
- out_valid  out  1  out_color is valid.
- out_ready  in  1  downstream accepts.
- out_color  out  15  blended pixel, BGR555.
- busy  out  1  a pixel is in flight.

Function
REQ-003 Handshake: a transfer occurs when in_valid=1 and in_ready=1. in_ready SHALL be 1 only in IDLE.
REQ-004 On accept, the block SHALL snapshot top_color, bot_color, top_is_t1, bot_is_t2, mode, EVA, EVB and EVY. Input changes after accept SHALL NOT affect the pixel in flight.
REQ-005 Effective operation SHALL be resolved at accept:
- mode 01 with top_is_t1 and bot_is_t2: alpha.
- mode 10 with top_is_t1: brighten.
- mode 11 with top_is_t1: darken.
- all other cases: passthrough of top_color.
REQ-006 The FSM SHALL have states IDLE, CH_R, CH_G, CH_B and OUT. Transitions:
- IDLE->CH_R on accept.
- CH_R->CH_G, CH_G->CH_B and CH_B->OUT, each unconditionally.
- OUT->IDLE when out_ready=1.
REQ-007 One shared channel arithmetic unit SHALL process R in CH_R, G in CH_G and B in CH_B. Each channel result SHALL be written into a 15-bit result register at its field.
REQ-008 Coefficients: each 5-bit EV value greater than 16 SHALL be treated as 16.
REQ-009 Alpha: (I1*EVA + I2*EVB)>>4, computed at 10 bits, saturated to 31.
REQ-010 Brighten: I + (((31-I)*EVY)>>4), never exceeding 31.
REQ-011 Darken: I - ((I*EVY)>>4), never below 0.
REQ-012 Passthrough SHALL still traverse CH_R..CH_B with result = top_color, unless REQ-019 applies.
REQ-013 Latency: accept in cycle N gives out_valid=1 in cycle N+4.
REQ-014 out_valid SHALL be 1 only in OUT. out_color SHALL equal the result register and stay stable while out_valid=1 and out_ready=0.
REQ-015 Throughput: in_ready returns to 1 in the cycle after the OUT handshake. No accept can coincide with an output handshake, so there is at most one pixel in flight.
REQ-016 busy SHALL be 1 in every state except IDLE.

Reset
REQ-017 With reset=1 at a clock edge, the block SHALL do all of the following:
- state goes to IDLE;
- out_valid=0, in_ready=1 (from the next cycle), busy=0, out_color=0;
- the snapshot registers and the result register are cleared.
REQ-018 Reset asserted in any state, including OUT with out_ready=0, SHALL discard the pixel in flight without emitting it.

Configuration
REQ-019 Macro BLEND_FASTPATH_EN. When defined, a passthrough pixel SHALL go IDLE->OUT directly with result=top_color (latency 1). Alpha, brighten and darken pixels keep latency 4. When undefined, all pixels take latency 4 per REQ-012 and REQ-013.

Verification
REQ-020 Alpha, mode 01, EVA=8, EVB=8, both target flags set, top=0x7FFF, bot=0x0000 -> out_color=0x3DEF (15 per channel) in cycle N+4.
REQ-021 Saturation, mode 01, EVA=16, EVB=16, top=0x5294, bot=0x5294 (20 per channel) -> out_color=0x7FFF. EVA=20 SHALL give the same result as EVA=16.
REQ-022 Brighten, mode 10, EVY=16, top=0x0000 -> 0x7FFF. Darken, mode 11, EVY=8, top=0x7FFF -> 0x4210 (16 per channel).
REQ-023 Mode 01 with bot_is_t2=0, top=0x1234 -> out 0x1234, at N+4 without the macro and N+1 with it.
REQ-024 Hold out_ready=0 for 5 cycles in OUT -> out_color stable and in_ready=0 throughout. Change bldalpha after accept -> result unchanged. Assert reset in CH_G -> no output, and IDLE with in_ready=1 in the following cycle.
